// File: rtl/up_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : up_counter                                                    |
// | Purpose  : N-bit modulo-(MAX_VAL+1) up counter with enable, terminal-    |
// |            count flag and registered wrap pulse. Optional macro          |
// |            UP_COUNTER_SATURATE_EN makes the counter stop at MAX_VAL.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module up_counter #(
  parameter int unsigned      N       = 4,
  parameter longint unsigned  MAX_VAL = (64'd1 << N) - 64'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         wrap
);

  // Out-of-range MAX_VAL falls back to the full N-bit range.
  localparam longint unsigned FULL_SCALE = (64'd1 << N) - 64'd1;
  localparam longint unsigned MAX_CLAMP  =
      ((MAX_VAL < 64'd1) || (MAX_VAL > FULL_SCALE)) ? FULL_SCALE : MAX_VAL;
  localparam logic [N-1:0]    MAX_C      = N'(MAX_CLAMP);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         at_max;

  assign at_max = (count_q == MAX_C);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (enable) begin
      if (at_max) begin
`ifdef UP_COUNTER_SATURATE_EN
        count_d = MAX_C;
        wrap_d  = 1'b0;
`else
        // Explicit compare selects the wrap so non-power-of-two moduli work.
        count_d = '0;
        wrap_d  = 1'b1;
`endif
      end else begin
        count_d = count_q + N'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tc    = at_max;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_up_counter.sv
`default_nettype none
// Bench for up_counter: full-range and MAX_VAL=9 instances checked every
// cycle against a modulo-arithmetic model plus directed literal expectations.
module tb_up_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] cnt_full;
  logic       tc_full;
  logic       wrap_full;
  logic [3:0] cnt_mod;
  logic       tc_mod;
  logic       wrap_mod;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit started   = 1'b0;

`ifdef UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  up_counter #(.N(4)) dut_full (
    .clk(clk), .rst(rst), .enable(enable),
    .count(cnt_full), .tc(tc_full), .wrap(wrap_full)
  );

  up_counter #(.N(4), .MAX_VAL(64'd9)) dut_mod (
    .clk(clk), .rst(rst), .enable(enable),
    .count(cnt_mod), .tc(tc_mod), .wrap(wrap_mod)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: value advances modulo (max+1), or saturates at max.
  int m_full, m_mod;
  bit w_full, w_mod;

  function automatic int next_val(input int m, input int max);
    if (SAT) return (m + 1 > max) ? max : m + 1;
    return (m + 1) % (max + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full <= 0; w_full <= 1'b0;
      m_mod  <= 0; w_mod  <= 1'b0;
    end else begin
      m_full <= enable ? next_val(m_full, 15) : m_full;
      m_mod  <= enable ? next_val(m_mod, 9)   : m_mod;
      w_full <= !SAT && enable && ((m_full + 1) % 16 == 0);
      w_mod  <= !SAT && enable && ((m_mod + 1) % 10 == 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_count_full", cnt_full, m_full);
      check("model_tc_full", tc_full, m_full == 15);
      check("model_wrap_full", wrap_full, w_full);
      check("model_count_mod", cnt_mod, m_mod);
      check("model_tc_mod", tc_mod, m_mod == 9);
      check("model_wrap_mod", wrap_mod, w_mod);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  int wraps_full, wraps_mod;

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    #1 started = 1'b1;
    #9;
    check("reset_count", cnt_full, 0);
    check("reset_tc", tc_full, 0);
    check("reset_wrap", wrap_full, 0);
    rst = 1'b0;
    tick(2);
    check("idle_after_release", cnt_full, 0);

    enable = 1'b1;
    tick(15);
    check("count_at_15", cnt_full, 15);
    check("tc_at_15", tc_full, 1);
    check("mod_count_after_15", cnt_mod, SAT ? 9 : 5);
    tick(1);
    check("count_after_wrap", cnt_full, SAT ? 15 : 0);
    check("wrap_pulse", wrap_full, SAT ? 0 : 1);
    tick(1);
    check("wrap_one_cycle", wrap_full, 0);
    tick(3);
    check("count_at_4", cnt_full, SAT ? 15 : 4);

    enable = 1'b0;
    tick(2);
    check("hold_count", cnt_full, SAT ? 15 : 4);
    check("hold_wrap", wrap_full, 0);
    enable = 1'b1;
    tick(1);
    check("resume_count", cnt_full, SAT ? 15 : 5);
    tick(4);
    check("count_at_9", cnt_full, SAT ? 15 : 9);

    // Asynchronous reset between edges, released before the next edge.
    rst = 1'b1;
    #1;
    check("async_reset_count", cnt_full, 0);
    check("async_reset_tc", tc_full, 0);
    #1 rst = 1'b0;
    tick(1);
    check("count_after_release", cnt_full, 1);

    // Hold at terminal count with enable low.
    rst = 1'b1; #1 rst = 1'b0;
    tick(9);
    check("mod_at_9", cnt_mod, 9);
    enable = 1'b0;
    tick(3);
    check("mod_hold_9", cnt_mod, 9);
    check("mod_hold_tc", tc_mod, 1);
    check("mod_hold_no_wrap", wrap_mod, 0);
    enable = 1'b1;

    // Count wrap pulses over 30 enabled edges from zero.
    rst = 1'b1; #1 rst = 1'b0;
    wraps_full = 0;
    wraps_mod  = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (wrap_full) wraps_full++;
      if (wrap_mod)  wraps_mod++;
    end
    check("mod_wrap_total", wraps_mod, SAT ? 0 : 3);
    check("full_wrap_total", wraps_full, SAT ? 0 : 1);
    check("full_after_30", cnt_full, SAT ? 15 : 14);
    check("mod_after_30", cnt_mod, SAT ? 9 : 0);
    check("full_tc_after_30", tc_full, SAT ? 1 : 0);

    rst = 1'b1;
    #1;
    check("final_reset", cnt_full, 0);
    #1 rst = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
